// File: rtl/pll_lock_sequencer_if.sv
// Status and control signals between the PLL lock sequencer (master) and the control logic (slave).
// lock_loss_cnt exists only when PLL_LOCK_LOSS_COUNT_EN is defined.
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt, lock_loss_cnt
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt, lock_loss_cnt
    );
`else
    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt
    );
    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt
    );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL start-up/recovery sequencer in the refclk domain: pulses PLL reset, waits for stable lock, then releases sys_rst.
// Define PLL_LOCK_LOSS_COUNT_EN to add the saturating lock_loss_cnt output.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYS_RST_DELAY       = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.master bus
);
    localparam int PH_MAX0 = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > SYS_RST_DELAY) ? PH_MAX0 : SYS_RST_DELAY;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] PULSE_LAST   = PH_W'(RST_PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0] STABLE_LAST  = PH_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [PH_W-1:0] DELAY_LAST   = PH_W'(SYS_RST_DELAY - 1);
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT_RST,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t          r_state;
    logic [PH_W-1:0] r_phaseCnt;
    logic [TO_W-1:0] r_timeoutCnt;
    logic [3:0]      r_retryCnt;
    logic            r_lockLost;
    logic            r_sync1;
    logic            r_lockedS;
    logic            r_pllRst;
    logic            r_sysRst;
    logic            r_ready;
    logic            r_fault;

    state_t          w_nextState;
    logic [PH_W-1:0] w_phaseNext;
    logic [TO_W-1:0] w_timeoutNext;
    logic [3:0]      w_retryNext;
    logic            w_lockLostNext;
    logic            w_timeoutHit;

    assign w_timeoutHit = (r_timeoutCnt == TIMEOUT_LAST);

    // One phase counter serves the PLL reset pulse, the stable-lock count and the release delay.
    always_comb begin
        w_nextState    = r_state;
        w_phaseNext    = r_phaseCnt;
        w_timeoutNext  = r_timeoutCnt;
        w_retryNext    = r_retryCnt;
        w_lockLostNext = r_lockLost;
        case (r_state)
            ST_ASSERT_RST: begin
                if (r_phaseCnt == PULSE_LAST) begin
                    w_nextState   = ST_WAIT_LOCK;
                    w_phaseNext   = '0;
                    w_timeoutNext = '0;
                end else begin
                    w_phaseNext = r_phaseCnt + PH_W'(1);
                end
            end
            ST_WAIT_LOCK, ST_STABILIZE: begin
                w_timeoutNext = r_timeoutCnt + TO_W'(1);
                if (w_timeoutHit) begin
                    w_phaseNext = '0;
                    if (r_retryCnt == RETRY_MAX) begin
                        w_nextState = ST_FAULT;
                    end else begin
                        w_retryNext = r_retryCnt + 4'd1;
                        w_nextState = ST_ASSERT_RST;
                    end
                end else if (r_state == ST_WAIT_LOCK) begin
                    if (r_lockedS) begin
                        w_nextState = ST_STABILIZE;
                        w_phaseNext = '0;
                    end
                end else if (!r_lockedS) begin
                    w_nextState = ST_WAIT_LOCK;
                end else if (r_phaseCnt == STABLE_LAST) begin
                    w_nextState = ST_RELEASE;
                    w_phaseNext = '0;
                end else begin
                    w_phaseNext = r_phaseCnt + PH_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!r_lockedS) begin
                    w_nextState = ST_ASSERT_RST;
                    w_phaseNext = '0;
                end else if (r_phaseCnt == DELAY_LAST) begin
                    w_nextState = ST_RUN;
                    w_retryNext = '0;
                end else begin
                    w_phaseNext = r_phaseCnt + PH_W'(1);
                end
            end
            ST_RUN: begin
                if (!r_lockedS || bus.relock_req) begin
                    w_nextState    = ST_ASSERT_RST;
                    w_phaseNext    = '0;
                    w_retryNext    = '0;
                    w_lockLostNext = r_lockLost | ~r_lockedS;
                end
            end
            ST_FAULT: begin
                if (bus.relock_req) begin
                    w_nextState = ST_ASSERT_RST;
                    w_phaseNext = '0;
                    w_retryNext = '0;
                end
            end
            default: begin
                w_nextState = ST_ASSERT_RST;
                w_phaseNext = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state      <= ST_ASSERT_RST;
            r_phaseCnt   <= '0;
            r_timeoutCnt <= '0;
            r_retryCnt   <= '0;
            r_lockLost   <= 1'b0;
            r_sync1      <= 1'b0;
            r_lockedS    <= 1'b0;
            r_pllRst     <= 1'b1;
            r_sysRst     <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_phaseCnt   <= w_phaseNext;
            r_timeoutCnt <= w_timeoutNext;
            r_retryCnt   <= w_retryNext;
            r_lockLost   <= w_lockLostNext;
            r_sync1      <= bus.pll_locked;
            r_lockedS    <= r_sync1;
            r_pllRst     <= (w_nextState == ST_ASSERT_RST) || (w_nextState == ST_FAULT);
            r_sysRst     <= (w_nextState != ST_RUN);
            r_ready      <= (w_nextState == ST_RUN);
            r_fault      <= (w_nextState == ST_FAULT);
        end
    end

    assign bus.pll_rst   = r_pllRst;
    assign bus.sys_rst   = r_sysRst;
    assign bus.ready     = r_ready;
    assign bus.fault     = r_fault;
    assign bus.lock_lost = r_lockLost;
    assign bus.retry_cnt = r_retryCnt;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [7:0] r_lockLossCnt;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lockLossCnt <= '0;
        end else if (r_state == ST_RUN && !r_lockedS && r_lockLossCnt != 8'hFF) begin
            r_lockLossCnt <= r_lockLossCnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = r_lockLossCnt;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus schedules expected output snapshots by cycle,
// a negedge monitor pops and compares them.
module tb_pll_lock_sequencer;
    localparam int P_PULSE   = 4;
    localparam int P_TIMEOUT = 100;
    localparam int P_STABLE  = 8;
    localparam int P_RETRIES = 2;
    localparam int P_DELAY   = 3;

    localparam logic [8:0] M_PRST = 9'h100;
    localparam logic [8:0] M_SRST = 9'h080;
    localparam logic [8:0] M_RDY  = 9'h040;
    localparam logic [8:0] M_FLT  = 9'h020;
    localparam logic [8:0] M_LL   = 9'h010;
    localparam logic [8:0] M_RC   = 9'h00F;
    localparam logic [8:0] M_ALL  = 9'h1FF;

    typedef struct {
        int         at;
        string      name;
        logic [8:0] mask;
        logic [8:0] val;
    } exp_t;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];
    exp_t e;
    logic [8:0] obs;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES(P_PULSE),
        .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
        .LOCK_STABLE_CYCLES(P_STABLE),
        .MAX_RETRIES(P_RETRIES),
        .SYS_RST_DELAY(P_DELAY)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .bus(bus.master)
    );

    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [8:0] pk(input logic prst, input logic srst, input logic rdy,
                                      input logic flt, input logic ll, input logic [3:0] rc);
        return {prst, srst, rdy, flt, ll, rc};
    endfunction

    // Monitor: every expectation stamped with the current cycle is compared against a snapshot.
    always @(negedge refclk) begin
        obs = {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault, bus.lock_lost, bus.retry_cnt};
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.at != cyc || (obs & e.mask) !== (e.val & e.mask)) begin
                fails++;
                $display("[TB] FAIL %s at cycle %0d: got %b required %b (mask %b)",
                         e.name, cyc, obs & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    task automatic checkOutput(input int at, input string name, input logic [8:0] mask, input logic [8:0] val);
        exp_t ne;
        int   i;
        ne.at   = at;
        ne.name = name;
        ne.mask = mask;
        ne.val  = val;
        i = q.size();
        while (i > 0 && q[i-1].at > at) i--;
        q.insert(i, ne);
    endtask

    task automatic applyStimulus(input logic r, input logic lk, input logic rq);
        rst            = r;
        bus.pll_locked = lk;
        bus.relock_req = rq;
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge refclk);
    endtask

    // Holds rst for two edges; base is the last edge that samples rst high.
    task automatic resetDut(input logic lk, output int base);
        applyStimulus(1'b1, lk, 1'b0);
        checkOutput(cyc + 1, "reset_first_edge", M_ALL, pk(1, 1, 0, 0, 0, 0));
        checkOutput(cyc + 2, "reset_state", M_ALL, pk(1, 1, 0, 0, 0, 0));
        waitUntil(cyc + 2);
        base = cyc;
        applyStimulus(1'b0, lk, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r, d, x, c;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge refclk);

        // Nominal lock
        resetDut(1'b0, r);
        checkOutput(r + 3,  "nom_pulse_end",   M_PRST, M_PRST);
        checkOutput(r + 4,  "nom_wait_lock",   M_PRST | M_SRST, M_SRST);
        checkOutput(r + 32, "nom_before_run",  M_RDY | M_SRST, M_SRST);
        checkOutput(r + 33, "nom_run",         M_ALL, pk(0, 0, 1, 0, 0, 0));
        waitUntil(r + 19);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(r + 40);

        // Lock loss while running, then relock
        d = cyc;
        checkOutput(d + 2,  "loss_still_run",  M_RDY | M_SRST, M_RDY);
        checkOutput(d + 3,  "loss_restart",    M_ALL, pk(1, 1, 0, 0, 1, 0));
        checkOutput(d + 6,  "loss_pulse_end",  M_PRST | M_LL, M_PRST | M_LL);
        checkOutput(d + 7,  "loss_wait_lock",  M_PRST | M_SRST | M_LL, M_SRST | M_LL);
        checkOutput(d + 18, "loss_before_run", M_RDY, 9'h000);
        checkOutput(d + 19, "loss_rerun",      M_ALL, pk(0, 0, 1, 0, 1, 0));
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitUntil(d + 3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(d + 25);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++;
        if (bus.lock_loss_cnt !== 8'd1) begin
            fails++;
            $display("[TB] FAIL loss_count: got %0d required 1", bus.lock_loss_cnt);
        end
`endif

        // Reset during RUN clears lock_lost; then a one-cycle lock glitch in STABILIZE
        resetDut(1'b0, r);
        checkOutput(r + 26, "glitch_no_pulse", M_PRST | M_RC, 9'h000);
        checkOutput(r + 30, "glitch_no_retry", M_PRST | M_RC | M_RDY, 9'h000);
        checkOutput(r + 33, "glitch_not_early", M_RDY, 9'h000);
        checkOutput(r + 37, "glitch_before_run", M_RDY, 9'h000);
        checkOutput(r + 38, "glitch_run",      M_ALL, pk(0, 0, 1, 0, 0, 0));
`ifdef PLL_LOCK_LOSS_COUNT_EN
        checks++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            fails++;
            $display("[TB] FAIL loss_count_reset: got %0d required 0", bus.lock_loss_cnt);
        end
`endif
        waitUntil(r + 19);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(r + 23);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitUntil(r + 24);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(r + 45);

        // Reset during STABILIZE, restart with lock already present
        resetDut(1'b0, r);
        waitUntil(r + 19);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(r + 25);
        resetDut(1'b1, r);
        checkOutput(r + 3,  "restart_pulse_end", M_PRST, M_PRST);
        checkOutput(r + 4,  "restart_wait",    M_PRST, 9'h000);
        checkOutput(r + 15, "restart_before_run", M_RDY, 9'h000);
        checkOutput(r + 16, "restart_run",     M_ALL, pk(0, 0, 1, 0, 0, 0));
        waitUntil(r + 20);

        // relock_req in RUN restarts; in STABILIZE it is ignored
        x = cyc;
        checkOutput(x + 1,  "relock_restart",  M_ALL, pk(1, 1, 0, 0, 0, 0));
        checkOutput(x + 9,  "relock_ignored",  M_PRST, 9'h000);
        checkOutput(x + 16, "relock_before_run", M_RDY, 9'h000);
        checkOutput(x + 17, "relock_run",      M_ALL, pk(0, 0, 1, 0, 0, 0));
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitUntil(x + 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(x + 8);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitUntil(x + 9);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(x + 22);

        // Never lock: retries then FAULT
        resetDut(1'b0, r);
        checkOutput(r + 103, "nolock_last_wait", M_PRST | M_RC, 9'h000);
        checkOutput(r + 104, "nolock_retry1",  M_PRST | M_RC, M_PRST | 9'h001);
        checkOutput(r + 107, "nolock_pulse2_end", M_PRST, M_PRST);
        checkOutput(r + 108, "nolock_wait2",   M_PRST | M_RC, 9'h001);
        checkOutput(r + 208, "nolock_retry2",  M_PRST | M_RC, M_PRST | 9'h002);
        checkOutput(r + 311, "nolock_pre_fault", M_PRST | M_FLT | M_RDY | M_RC, 9'h002);
        checkOutput(r + 312, "nolock_fault",   M_ALL, pk(1, 1, 0, 1, 0, 2));
        checkOutput(r + 320, "nolock_fault_hold", M_ALL, pk(1, 1, 0, 1, 0, 2));
        waitUntil(r + 320);

        // Recover from FAULT with relock_req and lock at the next attempt
        c = cyc;
        checkOutput(c + 1,  "fault_relock",    M_ALL, pk(1, 1, 0, 0, 0, 0));
        checkOutput(c + 16, "fault_before_run", M_RDY, 9'h000);
        checkOutput(c + 17, "fault_run",       M_ALL, pk(0, 0, 1, 0, 0, 0));
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitUntil(c + 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitUntil(c + 20);

        if (q.size() != 0) begin
            fails += q.size();
            $display("[TB] FAIL scoreboard_drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences start-up and recovery of the board PLL that produces the 143 MHz SDRAM and system clocks. It runs in the 50 MHz reference clock domain, which is live before the PLL locks. The block pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing a synchronous system reset. It monitors for lock loss and reports status to the Nios/QSYS control logic.

Parameters:
RST_PULSE_CYCLES, 10, refclk cycles pll_rst is held high per attempt (≥1)
LOCK_TIMEOUT_CYCLES, 50000, per-attempt window covering WAIT_LOCK and STABILIZE together (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
MAX_RETRIES, 3, extra attempts after the first; range 0..15
SYS_RST_DELAY, 16, cycles sys_rst stays high after stable lock

Ports:
refclk  in  1  50 MHz reference clock, the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked output, asynchronous to refclk
relock_req  in  1  single-cycle request to restart the sequence
pll_rst  out  1  drives PLL rst
sys_rst  out  1  synchronous active-high reset for downstream logic
ready  out  1  high in RUN only
fault  out  1  high in FAULT only
lock_lost  out  1  sticky; set on lock loss in RUN
retry_cnt  out  4  timeouts in the current sequence

Behaviour:
- Clocking/reset: single clock refclk; reset rst is synchronous and active-high. rst has priority over all other inputs.
- Reset values: state=ASSERT_RST, pll_rst=1, sys_rst=1, ready=0, fault=0, lock_lost=0, retry_cnt=0, all counters=0, synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer (locked_s). No other logic uses the raw pll_locked input.
- All outputs are registered Moore decodes of the state, except the retry_cnt and lock_lost registers.
- ASSERT_RST: pll_rst=1, sys_rst=1. Stays exactly RST_PULSE_CYCLES cycles, then moves to WAIT_LOCK and clears the timeout counter.
- WAIT_LOCK: pll_rst=0, sys_rst=1. If locked_s=1, go to STABILIZE and clear the stable counter.
- STABILIZE: pll_rst=0, sys_rst=1. If locked_s=0, return to WAIT_LOCK. The timeout counter is not cleared and retry_cnt does not change. After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, go to RELEASE.
- Timeout counter: runs in both WAIT_LOCK and STABILIZE. On reaching LOCK_TIMEOUT_CYCLES:
  - if retry_cnt==MAX_RETRIES, go to FAULT;
  - otherwise increment retry_cnt and go to ASSERT_RST.
  - Timeout takes priority over a same-cycle transition to STABILIZE or RELEASE.
- RELEASE: sys_rst=1 for SYS_RST_DELAY cycles, then go to RUN and clear retry_cnt. If locked_s=0 during RELEASE, go to ASSERT_RST with no retry increment.
- RUN: sys_rst=0, ready=1.
  - If locked_s=0: set lock_lost, go to ASSERT_RST, clear retry_cnt. sys_rst goes high on the same edge.
  - If relock_req=1: go to ASSERT_RST, clear retry_cnt.
  - If both occur together, lock_lost is still set.
- FAULT: pll_rst=1, sys_rst=1, fault=1. Left only by rst, or by relock_req, which goes to ASSERT_RST and clears retry_cnt.
- relock_req is ignored in all states other than RUN and FAULT.
- lock_lost is cleared only by rst.
- Latency: if pll_locked is sampled high at edge N and stays high, then from edge N+2+LOCK_STABLE_CYCLES+SYS_RST_DELAY, ready=1 and sys_rst=0.
- Failure timing: with lock never achieved, fault rises (MAX_RETRIES+1)*(RST_PULSE_CYCLES+LOCK_TIMEOUT_CYCLES) cycles after rst deasserts.

Optional Feature:
PLL_LOCK_LOSS_COUNT_EN:
- Defined: adds output lock_loss_cnt[7:0]. It increments, saturating at 255, each time lock_lost would be set, and clears only on rst.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYS_RST_DELAY=3.
1. Nominal: release rst at cycle 0 and raise pll_locked at cycle 20 -> pll_rst high for cycles 0-3; ready=1 and sys_rst=0 from edge 33; retry_cnt=0.
2. Never lock -> three pll_rst pulses with retry_cnt stepping 0→1→2; fault=1 at cycle 312 with pll_rst=1; ready never rises.
3. Lock glitch: pll_locked high at 20, low for one cycle at 24, then high -> no new pll_rst pulse; retry_cnt stays 0; ready rises 10 cycles after the re-rise, plus 3.
4. Lock loss in RUN: drop pll_locked -> sys_rst=1 and ready=0 two edges later; lock_lost=1; pll_rst pulses for 4 cycles; re-lock returns to RUN with lock_lost still 1 (lock_loss_cnt=1 when the macro is defined).
5. From FAULT, pulse relock_req and lock at the next attempt -> fault=0, retry_cnt=0, then reaches RUN.
6. Assert rst during STABILIZE and during RUN -> all outputs at reset values on the next edge; the sequence restarts cleanly.
